scan_display_ctrl: RTL and testbench



---
 rtl/scan_display_pkg.sv | 17 +
 rtl/scan_display_ctrl_if.sv | 27 ++
 rtl/scan_display_ctrl_hex7seg.sv | 11 +
 rtl/scan_display_ctrl.sv | 96 +++++++++
 tb/tb_scan_display_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/scan_display_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: active-low hex glyphs,
// the all-dark cathode pattern and the legal parameter envelope.
package scan_display_pkg;

   localparam int DIGITS_MIN      = 2;
   localparam int DIGITS_MAX      = 16;
   localparam int REFRESH_DIV_MIN = 2;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Bit order {g,f,e,d,c,b,a}, active-low, entries 0..F.
   localparam logic [0:15][6:0] SEG_LUT = {
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/scan_display_ctrl_if.sv
// Display-side bundle: datapath inputs (enable, nibbles, points, mask) and pin outputs.
// No handshake; the scanner samples inputs only at slot start and drives pins every cycle.
interface scan_display_ctrl_if #(
   parameter int DIGITS = 8
);
   localparam int IDX_W = $clog2(DIGITS);

   logic                  en;
   logic [4*DIGITS-1:0]   data;
   logic [DIGITS-1:0]     dp;
   logic [DIGITS-1:0]     dig_en;
   logic [DIGITS-1:0]     an;
   logic [6:0]            seg;
   logic                  seg_dp;
   logic [IDX_W-1:0]      num;

   modport master (
      output en, data, dp, dig_en,
      input  an, seg, seg_dp, num
   );

   modport slave (
      input  en, data, dp, dig_en,
      output an, seg, seg_dp, num
   );

endinterface

// File: rtl/scan_display_ctrl_hex7seg.sv
// Hex nibble to active-low 7-segment glyph; purely combinational, zero latency.
module hex7seg_decoder
   import scan_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/scan_display_ctrl.sv
// Time-multiplexed common-anode scanner: prescaled slots, one-cold anodes, blanking, hex decode.
// Pin outputs lag the prescaler/index state by one cycle; NUM is the live index; no backpressure.
module scan_display_ctrl
   import scan_display_pkg::*;
#(
   parameter int DIGITS       = 8,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic               clk,
   input  logic               rst_n,
   scan_display_ctrl_if.slave bus
);

   localparam int IDX_W   = $clog2(DIGITS);
   localparam int PRESC_W = $clog2(REFRESH_DIV);

   if (DIGITS < DIGITS_MIN || DIGITS > DIGITS_MAX || REFRESH_DIV < REFRESH_DIV_MIN ||
       BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_param_check
      $error("scan_display_ctrl: illegal DIGITS/REFRESH_DIV/BLANK_CYCLES combination");
   end

   logic [PRESC_W-1:0] presc;
   logic [IDX_W-1:0]   idx;
   logic [3:0]         snap_nib;
   logic               snap_dp;
   logic               snap_en;
   logic [DIGITS-1:0]  an_q;
   logic [6:0]         seg_q;
   logic               seg_dp_q;

   logic               slot_start;
   logic               slot_end;
   logic               last_digit;
   logic               in_blank;
   logic [3:0]         cur_nib;
   logic               cur_dp;
   logic               cur_en;
   logic [6:0]         cur_seg;

   assign slot_start = (presc == '0);
   assign slot_end   = (32'(presc) == REFRESH_DIV - 1);
   assign last_digit = (32'(idx) == DIGITS - 1);
   assign in_blank   = (32'(presc) < BLANK_CYCLES);

   // On the slot's first cycle the snapshot still holds the previous digit, so the
   // live inputs for the new index feed the output stage directly.
   assign cur_nib = slot_start ? bus.data[{idx, 2'b00} +: 4] : snap_nib;
   assign cur_dp  = slot_start ? bus.dp[idx]                 : snap_dp;
   assign cur_en  = slot_start ? bus.dig_en[idx]             : snap_en;

   hex7seg_decoder u_dec (
      .nibble (cur_nib),
      .seg    (cur_seg)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc    <= '0;
         idx      <= '0;
         snap_nib <= '0;
         snap_dp  <= 1'b0;
         snap_en  <= 1'b0;
         an_q     <= '1;
         seg_q    <= SEG_OFF;
         seg_dp_q <= 1'b1;
      end else if (bus.en) begin
         if (slot_end) begin
            presc <= '0;
            idx   <= last_digit ? '0 : idx + 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end

         if (slot_start) begin
            snap_nib <= cur_nib;
            snap_dp  <= cur_dp;
            snap_en  <= cur_en;
         end

         an_q     <= (in_blank || !cur_en) ? '1 : ~(DIGITS'(1) << idx);
         seg_q    <= cur_en ? cur_seg : SEG_OFF;
         seg_dp_q <= cur_en ? ~cur_dp : 1'b1;
      end else begin
         an_q     <= '1;
         seg_q    <= SEG_OFF;
         seg_dp_q <= 1'b1;
      end
   end

   assign bus.an     = an_q;
   assign bus.seg    = seg_q;
   assign bus.seg_dp = seg_dp_q;
   assign bus.num    = idx;

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Directed bench for scan_display_ctrl: 4-digit table of scan/decode/mask vectors plus
// hand sequences for snapshot hold, enable freeze, async reset and a 5-digit wrap.
module tb_scan_display_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   scan_display_ctrl_if #(.DIGITS(4)) bus4 ();
   scan_display_ctrl_if #(.DIGITS(5)) bus5 ();

   scan_display_ctrl #(.DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4.slave)
   );

   scan_display_ctrl #(.DIGITS(5), .REFRESH_DIV(4), .BLANK_CYCLES(1)) dut5 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus5.slave)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      logic [3:0] dig_en;
      int         n;
      logic [1:0] num;
      logic [3:0] an;
      logic [6:0] seg;
      logic       sdp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [3:0] de, input int n, input logic [1:0] num,
                               input logic [3:0] an, input logic [6:0] seg, input logic sdp);
      vec_t v;
      v.dig_en = de;
      v.n      = n;
      v.num    = num;
      v.an     = an;
      v.seg    = seg;
      v.sdp    = sdp;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step();
   endtask

   // Release lands in the low phase, so the next posedge is edge 1 of the new run.
   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
   endtask

   initial begin
      bus4.en     = 1'b1;
      bus4.data   = 16'h1234;
      bus4.dp     = 4'b0010;
      bus4.dig_en = 4'hF;
      bus5.en     = 1'b1;
      bus5.data   = 20'h12345;
      bus5.dp     = 5'b00000;
      bus5.dig_en = 5'h1F;

      // Full mask: scan order, blank interval, decode and decimal point.
      vecs.push_back(mk(4'hF,  0, 2'd0, 4'hF, 7'h7F, 1'b1));
      vecs.push_back(mk(4'hF,  1, 2'd0, 4'hF, 7'h19, 1'b1));
      vecs.push_back(mk(4'hF,  2, 2'd0, 4'hF, 7'h19, 1'b1));
      vecs.push_back(mk(4'hF,  3, 2'd0, 4'hE, 7'h19, 1'b1));
      vecs.push_back(mk(4'hF,  7, 2'd0, 4'hE, 7'h19, 1'b1));
      vecs.push_back(mk(4'hF,  8, 2'd1, 4'hE, 7'h19, 1'b1));
      vecs.push_back(mk(4'hF,  9, 2'd1, 4'hF, 7'h30, 1'b0));
      vecs.push_back(mk(4'hF, 11, 2'd1, 4'hD, 7'h30, 1'b0));
      vecs.push_back(mk(4'hF, 16, 2'd2, 4'hD, 7'h30, 1'b0));
      vecs.push_back(mk(4'hF, 19, 2'd2, 4'hB, 7'h24, 1'b1));
      vecs.push_back(mk(4'hF, 27, 2'd3, 4'h7, 7'h79, 1'b1));
      vecs.push_back(mk(4'hF, 32, 2'd0, 4'h7, 7'h79, 1'b1));
      vecs.push_back(mk(4'hF, 33, 2'd0, 4'hF, 7'h19, 1'b1));
      vecs.push_back(mk(4'hF, 35, 2'd0, 4'hE, 7'h19, 1'b1));
      // Digits 1 and 3 masked: dark for their whole slot, slot timing unchanged.
      vecs.push_back(mk(4'h5,  9, 2'd1, 4'hF, 7'h7F, 1'b1));
      vecs.push_back(mk(4'h5, 11, 2'd1, 4'hF, 7'h7F, 1'b1));
      vecs.push_back(mk(4'h5, 14, 2'd1, 4'hF, 7'h7F, 1'b1));
      vecs.push_back(mk(4'h5, 16, 2'd2, 4'hF, 7'h7F, 1'b1));
      vecs.push_back(mk(4'h5, 19, 2'd2, 4'hB, 7'h24, 1'b1));
      vecs.push_back(mk(4'h5, 24, 2'd3, 4'hB, 7'h24, 1'b1));
      vecs.push_back(mk(4'h5, 27, 2'd3, 4'hF, 7'h7F, 1'b1));
      vecs.push_back(mk(4'h5, 32, 2'd0, 4'hF, 7'h7F, 1'b1));
      vecs.push_back(mk(4'h5, 35, 2'd0, 4'hE, 7'h19, 1'b1));

      for (int i = 0; i < vecs.size(); i++) begin
         if (i == 0 || vecs[i].dig_en != vecs[i-1].dig_en || vecs[i].n < cyc) begin
            bus4.dig_en = vecs[i].dig_en;
            do_reset();
         end
         run_to(vecs[i].n);
         chk($sformatf("vec%0d_num", i), 32'(bus4.num), 32'(vecs[i].num));
         chk($sformatf("vec%0d_an", i), 32'(bus4.an), 32'(vecs[i].an));
         chk($sformatf("vec%0d_seg", i), 32'(bus4.seg), 32'(vecs[i].seg));
         chk($sformatf("vec%0d_seg_dp", i), 32'(bus4.seg_dp), 32'(vecs[i].sdp));
      end

      // Snapshot: nibble change mid-slot 0 appears only on the next visit to digit 0.
      bus4.dig_en = 4'hF;
      bus4.data   = 16'h1234;
      do_reset();
      run_to(3);
      bus4.data = 16'h1238;
      run_to(5);
      chk("snap_hold_mid", 32'(bus4.seg), 32'h19);
      run_to(8);
      chk("snap_hold_end", 32'(bus4.seg), 32'h19);
      run_to(33);
      chk("snap_new_first", 32'(bus4.seg), 32'h00);
      run_to(35);
      chk("snap_new_lit", 32'(bus4.seg), 32'h00);
      chk("snap_new_an", 32'(bus4.an), 32'hE);

      // Enable freeze at prescaler 5 of digit 2.
      bus4.data = 16'h1234;
      do_reset();
      run_to(21);
      chk("frz_pre_num", 32'(bus4.num), 32'd2);
      bus4.en = 1'b0;
      step();
      chk("frz_an", 32'(bus4.an), 32'hF);
      chk("frz_seg", 32'(bus4.seg), 32'h7F);
      for (int k = 0; k < 19; k++) step();
      chk("frz_hold_num", 32'(bus4.num), 32'd2);
      chk("frz_hold_an", 32'(bus4.an), 32'hF);
      bus4.en = 1'b1;
      step();
      chk("resume_an", 32'(bus4.an), 32'hB);
      chk("resume_seg", 32'(bus4.seg), 32'h24);
      chk("resume_num1", 32'(bus4.num), 32'd2);
      step();
      chk("resume_num2", 32'(bus4.num), 32'd2);
      step();
      chk("resume_num3", 32'(bus4.num), 32'd3);

      // Asynchronous reset mid-slot 3 with the clock held low.
      do_reset();
      run_to(28);
      chk("arst_pre_num", 32'(bus4.num), 32'd3);
      rst_n = 1'b0;
      #1;
      chk("arst_an", 32'(bus4.an), 32'hF);
      chk("arst_seg", 32'(bus4.seg), 32'h7F);
      chk("arst_seg_dp", 32'(bus4.seg_dp), 32'd1);
      chk("arst_num", 32'(bus4.num), 32'd0);
      rst_n = 1'b1;
      cyc = 0;
      run_to(2);
      chk("arst_blank", 32'(bus4.an), 32'hF);
      run_to(3);
      chk("arst_first_an", 32'(bus4.an), 32'hE);
      chk("arst_first_num", 32'(bus4.num), 32'd0);

      // Five digits: index wraps 4 -> 0 with no unused code.
      do_reset();
      run_to(17);
      chk("d5_num4", 32'(bus5.num), 32'd4);
      run_to(19);
      chk("d5_an4", 32'(bus5.an), 32'h0F);
      chk("d5_seg4", 32'(bus5.seg), 32'h79);
      run_to(20);
      chk("d5_wrap_num", 32'(bus5.num), 32'd0);
      run_to(21);
      chk("d5_wrap_an", 32'(bus5.an), 32'h1F);
      chk("d5_wrap_seg", 32'(bus5.seg), 32'h12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
